part2_mac: RTL and testbench
============================

Name: part2_mac

Overview:
- Pipelined signed multiply-accumulate (MAC) with saturating accumulation: f accumulates the products a*b.
- The accumulator clamps at the 28-bit signed limits instead of wrapping.
- Building-block datapath element for the neural-network accelerator's dot-product / MAC arrays.
- Handshake is valid_in / valid_out, with no backpressure.

Parameters:
- IN_W, 14, signed width of operands a and b.
- OUT_W, 28, signed width of the accumulator / output f (must be 2*IN_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- a  input  IN_W  signed multiplicand.
- b  input  IN_W  signed multiplier.
- valid_in  input  1  high when a, b hold an operand pair to accumulate.
- f  output  OUT_W  signed saturated running sum.
- valid_out  output  1  high for one cycle per accepted pair: f has just been updated.

Behaviour:
- Stage 1, input registers:
  - Every rising edge: a_r <= a, b_r <= b, v_r <= valid_in.
  - Unconditional capture.
- Stage 2, accumulate:
  - Every rising edge: if v_r, f <= sat(f + a_r*b_r); else f holds.
  - valid_out <= v_r.
- Latency:
  - Pair presented before edge N is reflected in f after edge N+1.
  - valid_out is high in that same cycle.
  - Throughput is one pair per cycle.
- valid_in low: pair ignored; f unchanged; valid_out low two edges later.
- Product rules:
  - Full signed IN_W x IN_W product, OUT_W bits.
  - Never overflows for IN_W=14; extreme case -8192*-8192 = 67108864.
- Sum rules:
  - Computed at OUT_W+1 bits, or overflow detected as "operand signs equal and result sign differs".
  - Positive overflow -> f = 134217727 (2^27-1).
  - Negative overflow -> f = -134217728 (-2^27).
  - Otherwise f = exact sum.
- Saturation is not sticky: accumulation continues from the clamped value, so subsequent opposite-sign products reduce it normally.
- Reset (reset low, async):
  - a_r, b_r, v_r, f, valid_out all 0.
  - Outputs read 0 / 0 while reset is held.
  - Reset mid-stream discards any in-flight pair and the accumulated sum.
  - First pair after deassertion accumulates from 0.
- No X propagation: f is registered directly, not combinational from the inputs.

Decomposition:
- Package mac_pkg:
  - IN_W, OUT_W.
  - ACC_MAX = 2^(OUT_W-1)-1, ACC_MIN = -2^(OUT_W-1).
  - typedefs: operand_t (signed IN_W), acc_t (signed OUT_W).
- One natural sub-module, sat_add:
  - Combinational OUT_W signed adder with overflow detect and clamp to ACC_MAX/ACC_MIN.
  - Instantiated in stage 2.

Test Plan:
- Reset then valid pairs (0,0),(8191,8191),(8191,8191) -> f = 0, 67092481, 134184962 on successive valid_out cycles.
- Continue with (1000,1000) -> f = 134217727 (positive saturation); then (-1000,1260) -> f = 132957727 (non-sticky recovery).
- Continue with (1300,1780), (1400,33), (1000,1000) -> f = 134217727 each cycle (repeated clamp).
- Pull reset low for one cycle mid-stream -> f = 0 and valid_out = 0 immediately (asynchronous).
- Then (-8192,8191) x2 -> f = -67100672, -134201344; then (1000,-1000) -> f = -134217728; then (1,-1) -> stays -134217728.
- Interleave valid_in=0 cycles carrying nonzero a,b -> f unchanged and valid_out low exactly two edges after each invalid input.
- Back-to-back valid pairs with no gaps -> one update per cycle, with valid_out continuously high.

Source files
------------

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Widths, saturation limits and types for the signed MAC.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int IN_W  = 14;
    localparam int OUT_W = 2 * IN_W;

    localparam logic signed [OUT_W-1:0] ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef logic signed [IN_W-1:0]  operand_t;
    typedef logic signed [OUT_W-1:0] acc_t;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
// Module      : sat_add
// Description : Combinational signed adder clamping to ACC_MAX / ACC_MIN.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add
    import mac_pkg::*;
(
    input  logic signed [OUT_W-1:0] acc,
    input  logic signed [OUT_W-1:0] addend,
    output logic signed [OUT_W-1:0] sum
);

    logic signed [OUT_W-1:0] w_raw;
    logic                    w_ovf;

    assign w_raw = acc + addend;
    // Overflow only when both operands share a sign the result does not.
    assign w_ovf = (acc[OUT_W-1] == addend[OUT_W-1]) && (w_raw[OUT_W-1] != acc[OUT_W-1]);

    always_comb begin
        sum = w_raw;
        if (w_ovf) begin
            sum = acc[OUT_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule : sat_add
`default_nettype wire

// File: rtl/part2_mac.sv
`default_nettype none
// ============================================================================
// Module      : part2_mac
// Description : Two-stage pipelined signed MAC with saturating accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module part2_mac
    import mac_pkg::*;
#(
    parameter int IN_W_P  = IN_W,
    parameter int OUT_W_P = OUT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [IN_W_P-1:0]  a,
    input  logic signed [IN_W_P-1:0]  b,
    input  logic                      valid_in,
    output logic signed [OUT_W_P-1:0] f,
    output logic                      valid_out
);

    operand_t r_a;
    operand_t r_b;
    logic     r_v;
    acc_t     r_f;
    logic     r_valid_out;

    acc_t w_a_ext;
    acc_t w_b_ext;
    acc_t w_prod;
    acc_t w_next;

    // Sign-extend first so the full-width product never overflows.
    assign w_a_ext = acc_t'(r_a);
    assign w_b_ext = acc_t'(r_b);
    assign w_prod  = w_a_ext * w_b_ext;

    sat_add u_sat_add (
        .acc    (r_f),
        .addend (w_prod),
        .sum    (w_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_v         <= 1'b0;
            r_f         <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_a         <= a;
            r_b         <= b;
            r_v         <= valid_in;
            r_valid_out <= r_v;
            if (r_v) begin
                r_f <= w_next;
            end
        end
    end

    assign f         = r_f;
    assign valid_out = r_valid_out;

endmodule : part2_mac
`default_nettype wire

// File: tb/tb_part2_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_part2_mac
// Description : Self-checking bench for part2_mac against a saturating model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_part2_mac;

    localparam longint C_MAX = 134217727;
    localparam longint C_MIN = -134217728;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic signed [13:0]  a = '0;
    logic signed [13:0]  b = '0;
    logic                valid_in = 1'b0;
    logic signed [27:0]  f;
    logic                valid_out;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    typedef struct {bit v; longint p;} pair_t;
    typedef struct {int cyc; longint f; bit vo;} lit_t;

    pair_t  pipe[$];
    pair_t  e;
    lit_t   lit[$];
    longint acc = 0;
    bit     exp_vo = 1'b0;

    part2_mac dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .f         (f),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    function automatic longint clamp(input longint x);
        if (x > C_MAX) return C_MAX;
        if (x < C_MIN) return C_MIN;
        return x;
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Model: each accepted pair lands one edge after it is captured.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe.delete();
            acc    = 0;
            exp_vo = 1'b0;
        end else begin
            exp_vo = 1'b0;
            if (pipe.size() > 0) begin
                e      = pipe.pop_front();
                exp_vo = e.v;
                if (e.v) acc = clamp(acc + e.p);
            end
            pipe.push_back('{valid_in, longint'(a) * longint'(b)});
        end
    end

    always @(negedge clk) begin
        tests++;
        if ($isunknown({f, valid_out}) || longint'(f) != acc || valid_out != exp_vo) begin
            fails++;
            $display("FAIL model cyc=%0d: f=%0d vo=%b, required f=%0d vo=%b",
                     cycle, f, valid_out, acc, exp_vo);
        end
        while (lit.size() > 0 && lit[0].cyc <= cycle) begin
            tests++;
            if (lit[0].cyc != cycle || $isunknown(f) || longint'(f) != lit[0].f
                || valid_out != lit[0].vo) begin
                fails++;
                $display("FAIL literal cyc=%0d: f=%0d vo=%b, required f=%0d vo=%b",
                         cycle, f, valid_out, lit[0].f, lit[0].vo);
            end
            void'(lit.pop_front());
        end
    end

    task automatic send(input int av, input int bv, input bit v,
                        input bit chk, input longint ef);
        @(posedge clk);
        #1;
        a        = 14'(av);
        b        = 14'(bv);
        valid_in = v;
        if (chk) lit.push_back('{cycle + 2, ef, 1'b1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(5, 7, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        send(0, 0, 1'b1, 1'b1, 0);
        send(8191, 8191, 1'b1, 1'b1, 67092481);
        send(8191, 8191, 1'b1, 1'b1, 134184962);
        send(1000, 1000, 1'b1, 1'b1, C_MAX);
        send(-1000, 1260, 1'b1, 1'b1, 132957727);
        send(1300, 1780, 1'b1, 1'b1, C_MAX);
        send(1400, 33, 1'b1, 1'b1, C_MAX);
        send(1000, 1000, 1'b1, 1'b1, C_MAX);
        idle(3);

        // One-cycle reset pulse: outputs must clear before the next edge.
        @(posedge clk);
        #1;
        reset    = 1'b0;
        valid_in = 1'b0;
        lit.push_back('{cycle, 0, 1'b0});
        @(posedge clk);
        #1 reset = 1'b1;

        send(-8192, 8191, 1'b1, 1'b1, -67100672);
        send(-8192, 8191, 1'b1, 1'b1, -134201344);
        send(1000, -1000, 1'b1, 1'b1, C_MIN);
        send(1, -1, 1'b1, 1'b1, C_MIN);

        send(100, 100, 1'b1, 1'b1, -134207728);
        send(77, 99, 1'b0, 1'b0, 0);
        send(-2, 3, 1'b1, 1'b1, -134207734);
        send(-300, 411, 1'b0, 1'b0, 0);
        send(8191, 8191, 1'b0, 1'b0, 0);
        send(50, -1, 1'b1, 1'b1, -134207784);

        send(-8192, -8192, 1'b1, 1'b1, -67098920);
        send(-8192, -8192, 1'b1, 1'b1, 9944);
        send(-8192, -8192, 1'b1, 1'b1, 67118808);
        send(8191, -8192, 1'b1, 1'b1, 18136);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_part2_mac
`default_nettype wire
